case_2_mac_pipe: RTL and testbench
==================================

CASE_2_MAC_PIPE -- requirements
Module: case_2_mac_pipe

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 2, pipeline latency in cycles; legal range 1..4.
REQ-003 SHALL have parameter din0_WIDTH, default 8, signed operand A width.
REQ-004 SHALL have parameter din1_WIDTH, default 6, signed operand B width.
REQ-005 SHALL have parameter dout_WIDTH, default 16, result/accumulator width; must be >= din0_WIDTH+din1_WIDTH.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-008 SHALL have port ce, input, 1, global clock enable; low freezes all state.
REQ-009 SHALL have port in_valid, input, 1, operand beat present.
REQ-010 SHALL have port in_ready, output, 1, beat accepted when in_valid&&in_ready&&ce.
REQ-011 SHALL have port din0, input, din0_WIDTH, signed operand A.
REQ-012 SHALL have port din1, input, din1_WIDTH, signed operand B.
REQ-013 SHALL have port acc_en, input, 1, beat adds to accumulator (1) or passes product alone (0).
REQ-014 SHALL have port acc_clr, input, 1, beat restarts accumulation: acc = product.
REQ-015 SHALL have port out_valid, output, 1, dout holds a result.
REQ-016 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-017 SHALL have port dout, output, dout_WIDTH, signed result.
REQ-018 SHALL have port ovf, output, 1, sticky accumulator overflow flag.

Function
REQ-019 SHALL compute product = signed(din0)*signed(din1), sign-extended to dout_WIDTH, exact.
REQ-020 SHALL present each accepted beat's result on dout exactly NUM_STAGE enabled, unstalled cycles after acceptance, in order.
REQ-021 SHALL stall the whole pipeline when out_valid && !out_ready; in_ready = ce && !stall (combinational).
REQ-022 SHALL hold dout/out_valid stable while stalled; no beat is dropped or duplicated.
REQ-023 SHALL carry acc_en/acc_clr alongside data; the accumulator updates only in the final stage when a beat leaves the pipeline's last register.
REQ-024 SHALL output product when acc_en=0 and leave the accumulator unchanged.
REQ-025 SHALL, with acc_en=1, acc_clr=1, load acc=product and output it.
REQ-026 SHALL, with acc_en=1, acc_clr=0, load acc=acc+product (dout_WIDTH arithmetic) and output it.
REQ-027 SHALL set ovf when a signed overflow occurs in REQ-026; ovf clears only on acc_clr beat or reset.
REQ-028 SHALL propagate bubbles (in_valid=0) as invalid slots without altering the accumulator.
REQ-029 SHALL, when ce=0, freeze every register including out_valid; in_ready=0.

Reset
REQ-030 SHALL on reset clear all stage valid bits, accumulator, dout=0, out_valid=0, ovf=0, immediately and asynchronously.
REQ-031 SHALL discard in-flight beats on reset mid-operation; first beat after deassertion behaves as after power-up.

Configuration
REQ-032 SHALL support macro CASE_2_MAC_SAT_EN: defined -> overflowing accumulation clamps to +2^(dout_WIDTH-1)-1 or -2^(dout_WIDTH-1); undefined -> two's-complement wrap; ovf behaves identically in both.

Structure
REQ-033 SHALL place saturation-bound constants, the overflow-detect function and the stage control-flag typedef in package case_2_mac_pkg.
REQ-034 SHALL use one sub-module case_2_mac_stage (valid+data+flags register slice with enable), instantiated NUM_STAGE-1 times.

Verification
REQ-035 SHALL cover: din0=-128, din1=-32, acc_en=0 -> dout=4096, out_valid exactly 2 cycles later.
REQ-036 SHALL cover: 8 back-to-back beats -128*-32, first acc_clr=1, rest acc_en=1 -> 8th dout=-32768, ovf=1 (wrap); 32767, ovf=1 (CASE_2_MAC_SAT_EN).
REQ-037 SHALL cover: out_ready=0 for 5 cycles during a 6-beat stream of 3*5 -> in_ready=0 while stalled, all 6 results (15) delivered in order.
REQ-038 SHALL cover: ce=0 for 3 cycles mid-stream -> all outputs frozen, latency extended by exactly 3 cycles.
REQ-039 SHALL cover: reset asserted with 2 beats in flight -> out_valid=0, dout=0, ovf=0 immediately; next beat 7*-2 with acc_en=1, acc_clr=0 -> dout=-14.
REQ-040 SHALL cover: din0=127, din1=31, acc_en=0 -> dout=3937; din0=-128, din1=31 -> dout=-3968.

Source files
------------

// File: rtl/case_2_mac_pkg.sv
// case_2_mac_pkg: shared definitions for the case_2_mac_pipe MAC pipeline.
//   - mac_flags_t : per-beat control flags carried alongside the product
//   - sat_pos/neg : saturation bounds for a given accumulator width
//   - add_ovf     : signed-add overflow detect from operand/sum sign bits
package case_2_mac_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int unsigned MaxWidth = 64;

    typedef struct packed {
        logic acc_en;
        logic acc_clr;
    } mac_flags_t;

    // Largest positive value of a signed number of the given width.
    function automatic logic [MaxWidth-1:0] sat_pos(input int unsigned width);
        return (MaxWidth'(1) << (width - 1)) - MaxWidth'(1);
    endfunction

    // Most negative value, sign-extended to MaxWidth; truncate at the use site.
    function automatic logic [MaxWidth-1:0] sat_neg(input int unsigned width);
        return ~sat_pos(width);
    endfunction

    // Overflow happens only when both addends share a sign the sum lacks.
    function automatic logic add_ovf(input logic a_sign, input logic b_sign,
                                     input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/case_2_mac_stage.sv
// case_2_mac_stage: one register slice of the MAC pipeline.
// Holds a valid bit, a data word and the control flags; loads when en_i is high.
// Ports:
//   clk_i, rst_i (async, active-high), en_i      : clock, reset, advance enable
//   valid_i, data_i, flags_i                     : slot entering the slice
//   valid_o, data_o, flags_o                     : registered slot
module case_2_mac_stage
    import case_2_mac_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    input  mac_flags_t       flags_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output mac_flags_t       flags_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;
    mac_flags_t       flags_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
            flags_q <= flags_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/case_2_mac_pipe.sv
// case_2_mac_pipe: signed multiply-accumulate pipeline with valid/ready flow control.
// Each accepted beat's product (din0*din1, sign-extended) travels NUM_STAGE-1 register
// slices; the final output register applies the accumulate operation and presents the
// result NUM_STAGE enabled, unstalled cycles after acceptance.
// Ports:
//   clk, reset (async, active-high), ce (global clock enable)
//   in_valid/in_ready, din0, din1, acc_en, acc_clr : operand beat
//   out_valid/out_ready, dout, ovf                 : result and sticky overflow
// Build option: define CASE_2_MAC_SAT_EN to clamp an overflowing accumulation to the
// signed range limits instead of wrapping.
module case_2_mac_pipe
    import case_2_mac_pkg::*;
#(
    parameter int          ID         = 1,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned din0_WIDTH = 8,
    parameter int unsigned din1_WIDTH = 6,
    parameter int unsigned dout_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int unsigned Last = NUM_STAGE - 1;
    localparam int unsigned Msb  = dout_WIDTH - 1;

    logic pipe_en;
    logic stall;

    // Slot 0 is the combinational input; slot i is the output of slice i.
    logic       [NUM_STAGE-1:0]                 s_valid;
    logic       [NUM_STAGE-1:0][dout_WIDTH-1:0] s_data;
    mac_flags_t [NUM_STAGE-1:0]                 s_flags;

    logic signed [dout_WIDTH-1:0] op_a;
    logic signed [dout_WIDTH-1:0] op_b;
    logic signed [dout_WIDTH-1:0] product;

    logic [dout_WIDTH-1:0] acc_q, acc_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;

    logic [dout_WIDTH-1:0] last_data;
    logic [dout_WIDTH-1:0] sum;
    logic [dout_WIDTH-1:0] acc_sum;
    logic                  add_overflow;

    // A held result blocks every stage so nothing is overwritten or lost.
    assign stall    = out_valid_q && !out_ready;
    assign pipe_en  = ce && !stall;
    assign in_ready = pipe_en;

    // Exact product: dout_WIDTH >= din0_WIDTH + din1_WIDTH, so no truncation.
    assign op_a    = dout_WIDTH'($signed(din0));
    assign op_b    = dout_WIDTH'($signed(din1));
    assign product = op_a * op_b;

    assign s_valid[0] = in_valid;
    assign s_data[0]  = product;
    assign s_flags[0] = {acc_en, acc_clr};

    for (genvar i = 1; i < NUM_STAGE; i++) begin : g_stage
        case_2_mac_stage #(
            .Width (dout_WIDTH)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (reset),
            .en_i    (pipe_en),
            .valid_i (s_valid[i-1]),
            .data_i  (s_data[i-1]),
            .flags_i (s_flags[i-1]),
            .valid_o (s_valid[i]),
            .data_o  (s_data[i]),
            .flags_o (s_flags[i])
        );
    end

    assign last_data    = s_data[Last];
    assign sum          = acc_q + last_data;
    assign add_overflow = add_ovf(acc_q[Msb], last_data[Msb], sum[Msb]);

`ifdef CASE_2_MAC_SAT_EN
    localparam logic [dout_WIDTH-1:0] SatPos = dout_WIDTH'(sat_pos(dout_WIDTH));
    localparam logic [dout_WIDTH-1:0] SatNeg = dout_WIDTH'(sat_neg(dout_WIDTH));

    // On overflow both addends share the accumulator's sign, which picks the rail.
    assign acc_sum = add_overflow ? (acc_q[Msb] ? SatNeg : SatPos) : sum;
`else
    assign acc_sum = sum;
`endif

    always_comb begin
        acc_d       = acc_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (pipe_en) begin
            out_valid_d = s_valid[Last];
            // Bubbles leave dout and the accumulator untouched.
            if (s_valid[Last]) begin
                if (!s_flags[Last].acc_en) begin
                    dout_d = last_data;
                end else if (s_flags[Last].acc_clr) begin
                    acc_d  = last_data;
                    dout_d = last_data;
                    ovf_d  = 1'b0;
                end else begin
                    acc_d  = acc_sum;
                    dout_d = acc_sum;
                    ovf_d  = ovf_q | add_overflow;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_case_2_mac_pipe.sv
// tb_case_2_mac_pipe: self-checking bench for case_2_mac_pipe (default parameters).
// Expected results come from a transaction-level model: each accepted beat is turned
// into its expected (dout, ovf) pair with plain integer arithmetic and queued; a
// monitor pops one entry per output handshake. Scenario tasks add targeted checks.
module tb_case_2_mac_pipe;

    localparam int MaxPos = 32767;
    localparam int MinNeg = -32768;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] din0;
    logic signed [5:0] din1;
    logic              acc_en;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] dout;
    logic              ovf;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    // Reference model state.
    int m_acc = 0;
    bit m_ovf = 1'b0;
    int exp_dout[$];
    bit exp_ovf[$];

    always #5 clk = ~clk;

    case_2_mac_pipe #(
        .ID         (1),
        .NUM_STAGE  (2),
        .din0_WIDTH (8),
        .din1_WIDTH (6),
        .dout_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .ovf       (ovf)
    );

    function automatic void model_beat(input int a, input int b, input bit en, input bit clr);
        int     p;
        longint s;
        p = a * b;
        if (!en) begin
            exp_dout.push_back(p);
        end else if (clr) begin
            m_acc = p;
            m_ovf = 1'b0;
            exp_dout.push_back(m_acc);
        end else begin
            s = longint'(m_acc) + longint'(p);
            if (s > MaxPos || s < MinNeg) begin
                m_ovf = 1'b1;
`ifdef CASE_2_MAC_SAT_EN
                s = (s > MaxPos) ? MaxPos : MinNeg;
`else
                s = longint'($signed(s[15:0]));
`endif
            end
            m_acc = int'(s);
            exp_dout.push_back(m_acc);
        end
        exp_ovf.push_back(m_ovf);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic drive_beat(input int a, input int b, input bit en, input bit clr);
        int k = 0;
        din0     = 8'(a);
        din1     = 6'(b);
        acc_en   = en;
        acc_clr  = clr;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            model_beat(a, b, en, clr);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_dout.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (exp_dout.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", exp_dout.size());
        end
    endtask

    // Scoreboard: one expected entry per output handshake, in order.
    initial begin
        int ed;
        bit eo;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && ce && out_valid && out_ready) begin
                n_out++;
                checks++;
                if (exp_dout.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: dout=%0d required no output", dout);
                end else begin
                    ed = exp_dout.pop_front();
                    eo = exp_ovf.pop_front();
                    if (dout !== 16'(ed)) begin
                        errors++;
                        $display("FAIL sb_dout: got %0d required %0d", dout, ed);
                    end
                    checks++;
                    if (ovf !== eo) begin
                        errors++;
                        $display("FAIL sb_ovf: got %0b required %0b", ovf, eo);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
        if (dout !== 16'sd0)    begin errors++; $display("FAIL rst_dout: got %0d required 0", dout); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf: got %0b required 0", ovf); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        drive_beat(-128, -32, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid=%0b required 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0b required 1", out_valid); end
        if (dout !== 16'sd4096) begin errors++; $display("FAIL lat_dout: got %0d required 4096", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_extremes();
        drive_beat(127, 31, 1'b0, 1'b0);
        drive_beat(-128, 31, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (dout !== 16'sd3937) begin errors++; $display("FAIL ext_pos: got %0d required 3937", dout); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (dout !== -16'sd3968) begin errors++; $display("FAIL ext_neg: got %0d required -3968", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_accum();
        int want;
`ifdef CASE_2_MAC_SAT_EN
        want = 32767;
`else
        want = -32768;
`endif
        drive_beat(-128, -32, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) drive_beat(-128, -32, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL acc8_valid: got %0b required 1", out_valid); end
        if (dout !== 16'(want)) begin errors++; $display("FAIL acc8_dout: got %0d required %0d", dout, want); end
        if (ovf !== 1'b1)       begin errors++; $display("FAIL acc8_ovf: got %0b required 1", ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        drive_beat(1, 1, 1'b1, 1'b0);
        drive_beat(2, 2, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b required 1", out_valid); end
        reset = 1'b1;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b required 0", out_valid); end
        if (dout !== 16'sd0)    begin errors++; $display("FAIL mid_dout: got %0d required 0", dout); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL mid_ovf: got %0b required 0", ovf); end
        exp_dout.delete();
        exp_ovf.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        drive_beat(7, -2, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_early: out_valid=%0b required 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL post_valid: got %0b required 1", out_valid); end
        if (dout !== -16'sd14)  begin errors++; $display("FAIL post_dout: got %0d required -14", dout); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL post_ovf: got %0b required 0", ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_ce_freeze();
        drive_beat(3, 5, 1'b0, 1'b0);
        drive_beat(-7, 9, 1'b0, 1'b0);
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL ce_valid[%0d]: got %0b required 1", c, out_valid); end
            if (dout !== 16'sd15)   begin errors++; $display("FAIL ce_dout[%0d]: got %0d required 15", c, dout); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL ce_in_ready[%0d]: got %0b required 0", c, in_ready); end
            @(posedge clk); #1;
        end
        ce = 1'b1;
        @(negedge clk);
        checks++;
        if (dout !== 16'sd15) begin errors++; $display("FAIL ce_resume_a: got %0d required 15", dout); end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ce_resume_valid: got %0b required 1", out_valid); end
        if (dout !== -16'sd63)  begin errors++; $display("FAIL ce_resume_b: got %0d required -63", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) drive_beat(3, 5, 1'b0, 1'b0);
            end
            begin
                int k = 0;
                @(negedge clk);
                while (!out_valid && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checks += 3;
                    if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b required 0", c, in_ready); end
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b required 1", c, out_valid); end
                    if (dout !== 16'sd15)   begin errors++; $display("FAIL stall_dout[%0d]: got %0d required 15", c, dout); end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (n_out - base != 6) begin
            errors++;
            $display("FAIL stall_count: delivered %0d required 6", n_out - base);
        end
    endtask

    task automatic test_random();
        int base = n_out;
        bit done = 1'b0;
        fork
            begin
                logic signed [7:0] ra;
                logic signed [5:0] rb;
                bit en, clr;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    ra  = 8'($urandom);
                    rb  = 6'($urandom);
                    en  = 1'($urandom_range(0, 1));
                    clr = en && ($urandom_range(0, 3) == 0);
                    drive_beat(int'(ra), int'(rb), en, clr);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (n_out - base != 40) begin
            errors++;
            $display("FAIL rand_count: delivered %0d required 40", n_out - base);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        wait_drain();
        test_extremes();
        wait_drain();
        test_accum();
        wait_drain();
        test_reset_midflight();
        wait_drain();
        test_ce_freeze();
        wait_drain();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
